// File: rtl/rr_grant_ctrl_8.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// Grants are held until done, request drop, disable or the MAX_HOLD limit; every output is registered.
module rr_grant_ctrl_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    ptr, ptr_nxt;
    logic [2:0]    gnt_id_nxt;
    logic [7:0]    gnt_nxt;
    logic          vld_nxt;
    logic          timeout_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic [3:0]    pick;
    logic          rel_any;
    logic          rel_max;

    // Search upward from p with wrap; the lowest offset from p wins. Bit 3 flags a hit.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // 3-to-8 decoder: e gates the decode, output is 1 << a.
    function automatic logic [7:0] dec3to8(input logic e, input logic [2:0] a);
        return e ? (8'b1 << a) : 8'b0;
    endfunction

    assign pick    = rr_pick(req, ptr);
    assign rel_max = (hold_cnt == CW'(MAX_HOLD));
    assign rel_any = !en || done || !req[gnt_id] || rel_max;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_id_nxt  = gnt_id;
        vld_nxt     = 1'b0;
        timeout_nxt = 1'b0;
        hold_nxt    = hold_cnt;
        case (state)
            IDLE: begin
                if (en && pick[3]) begin
                    state_nxt  = GRANT;
                    gnt_id_nxt = pick[2:0];
                    vld_nxt    = 1'b1;
                    hold_nxt   = CW'(1);
                end
            end
            GRANT: begin
                if (rel_any) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = gnt_id + 3'd1;
                    hold_nxt    = '0;
                    // Only a pure hold-limit revocation is reported.
                    timeout_nxt = en && !done && req[gnt_id] && rel_max;
                end else begin
                    vld_nxt  = 1'b1;
                    hold_nxt = hold_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        gnt_nxt = dec3to8(vld_nxt, gnt_id_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            gnt      <= 8'b0;
            gnt_id   <= 3'd0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            gnt_vld  <= vld_nxt;
            timeout  <= timeout_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule
